// File: rtl/univ_shift_reg.sv
// Universal shift register: hold / shift-left / shift-right / parallel load, with a saturating
// shift counter and a one-cycle frame_done pulse. Define ROTATE_EN to turn shifts into rotates.
module univ_shift_reg #(
  parameter  int WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_r,
  input  logic             sin_l,
  output logic [WIDTH-1:0] q,
  output logic             sout_l,
  output logic             sout_r,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             frame_done
);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] r_q;
  logic [CNT_W-1:0] r_cnt;
  logic             r_fd;

  logic [WIDTH-1:0] w_q_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_fd_nxt;
  logic             w_shift;
  logic             w_in_lsb;
  logic             w_in_msb;

`ifdef ROTATE_EN
  assign w_in_lsb = r_q[WIDTH-1];
  assign w_in_msb = r_q[0];
`else
  assign w_in_lsb = sin_r;
  assign w_in_msb = sin_l;
`endif

  // Any mode other than an exact 01/10/11 (including X in simulation) falls to hold.
  always_comb begin
    w_q_nxt   = r_q;
    w_cnt_nxt = r_cnt;
    w_fd_nxt  = 1'b0;
    w_shift   = 1'b0;
    case (mode)
      2'b01: begin
        w_q_nxt = {r_q[WIDTH-2:0], w_in_lsb};
        w_shift = 1'b1;
      end
      2'b10: begin
        w_q_nxt = {w_in_msb, r_q[WIDTH-1:1]};
        w_shift = 1'b1;
      end
      2'b11: begin
        w_q_nxt   = d;
        w_cnt_nxt = '0;
      end
      default: ;
    endcase
    // Counter saturates at WIDTH; the pulse fires only on the WIDTH-1 -> WIDTH step.
    if (w_shift && (r_cnt < CNT_MAX)) begin
      w_cnt_nxt = r_cnt + 1'b1;
      w_fd_nxt  = (r_cnt == CNT_LAST);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q   <= '0;
      r_cnt <= '0;
      r_fd  <= 1'b0;
    end else begin
      r_q   <= w_q_nxt;
      r_cnt <= w_cnt_nxt;
      r_fd  <= w_fd_nxt;
    end
  end

  assign q          = r_q;
  assign sout_l     = r_q[WIDTH-1];
  assign sout_r     = r_q[0];
  assign shift_cnt  = r_cnt;
  assign frame_done = r_fd;

endmodule
